// File: rtl/fruit_split_motion.sv
// Per-fruit motion controller: ballistic launch, split into two halves on a cut,
// per-half retirement at the screen edges, with miss/done reporting.
module fruit_split_motion #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int OBJ_W       = 64,
  parameter int LAUNCH_Y    = 479,
  parameter int GRAVITY_DIV = 4,
  parameter int SPLIT_VX    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       launch,
  input  logic [9:0] launch_x,
  input  logic [7:0] launch_vx,
  input  logic [7:0] launch_vy,
  input  logic       cut,
  output logic       en1,
  output logic       en2,
  output logic [9:0] posx1,
  output logic [9:0] posy1,
  output logic [9:0] posx2,
  output logic [9:0] posy2,
  output logic       busy,
  output logic       cut_ack,
  output logic       missed,
  output logic       done
);

  localparam logic signed [11:0] HALF_W   = 12'(OBJ_W / 2);
  localparam logic signed [11:0] Y_MAX    = 12'(SCREEN_H - 1);
  localparam logic signed [11:0] XW_MAX   = 12'(SCREEN_W - OBJ_W);
  localparam logic signed [11:0] XH_MAX   = 12'(SCREEN_W - OBJ_W / 2);
  localparam logic signed [11:0] Y_LAUNCH = 12'(LAUNCH_Y);
  localparam logic [3:0]         G_TOP    = 4'(GRAVITY_DIV - 1);
  localparam logic signed [8:0]  KICK     = 9'(SPLIT_VX);

  typedef enum logic [1:0] {IDLE, WHOLE, SPLIT} state_t;

  state_t             state, state_n;
  logic signed [11:0] x1, x2, y, x1_n, x2_n, y_n, wx2;
  logic signed [7:0]  vx1, vx2, vy, vx1_n, vx2_n, vy_n;
  logic [3:0]         gcnt, gcnt_n;
  logic               alive1, alive2, alive1_n, alive2_n;
  logic               en1_n, en2_n, busy_n, cut_ack_n, missed_n, done_n;
  logic [9:0]         posx1_n, posy1_n, posx2_n, posy2_n;

  function automatic logic signed [11:0] sx(input logic signed [7:0] v);
    return {{4{v[7]}}, v};
  endfunction

  function automatic logic signed [7:0] clamp127(input logic signed [8:0] v);
    if (v > 9'sd127)  return 8'sd127;
    if (v < -9'sd127) return -8'sd127;
    return v[7:0];
  endfunction

  always_comb begin
    state_n   = state;
    x1_n      = x1;
    x2_n      = x2;
    y_n       = y;
    vx1_n     = vx1;
    vx2_n     = vx2;
    vy_n      = vy;
    gcnt_n    = gcnt;
    alive1_n  = alive1;
    alive2_n  = alive2;
    cut_ack_n = 1'b0;
    missed_n  = 1'b0;
    done_n    = 1'b0;
    wx2       = '0;

    // Shared vertical motion and gravity for both flying states
    if (state != IDLE && frame_tick) begin
      y_n = y + sx(vy);
      if (gcnt == G_TOP) begin
        gcnt_n = '0;
        if (vy != 8'sd127) vy_n = vy + 8'sd1;
      end else begin
        gcnt_n = gcnt + 4'd1;
      end
    end

    case (state)
      IDLE: begin
        if (launch) begin
          x1_n    = {2'b00, launch_x};
          y_n     = Y_LAUNCH;
          vx1_n   = launch_vx;
          vy_n    = launch_vy;
          gcnt_n  = '0;
          state_n = WHOLE;
        end
      end
      WHOLE: begin
        if (frame_tick) x1_n = x1 + sx(vx1);
        // A cut seeds the split from the already-updated x1 and pre-empts the miss test
        if (cut) begin
          cut_ack_n = 1'b1;
          x2_n      = x1_n + HALF_W;
          vx1_n     = clamp127({vx1[7], vx1} - KICK);
          vx2_n     = clamp127({vx1[7], vx1} + KICK);
          alive1_n  = 1'b1;
          alive2_n  = 1'b1;
          state_n   = SPLIT;
        end else if (frame_tick &&
                     ((y_n > Y_MAX && !vy_n[7]) || x1_n < 12'sd0 || x1_n > XW_MAX)) begin
          missed_n = 1'b1;
          state_n  = IDLE;
        end
      end
      SPLIT: begin
        if (frame_tick) begin
          if (alive1) x1_n = x1 + sx(vx1);
          if (alive2) x2_n = x2 + sx(vx2);
          alive1_n = alive1 && !((y_n > Y_MAX && !vy_n[7]) || x1_n < 12'sd0 || x1_n > XH_MAX);
          alive2_n = alive2 && !((y_n > Y_MAX && !vy_n[7]) || x2_n < 12'sd0 || x2_n > XH_MAX);
          if (!alive1_n && !alive2_n) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n  = (state_n != IDLE);
    en1_n   = 1'b0;
    en2_n   = 1'b0;
    posx1_n = posx1;
    posy1_n = posy1;
    posx2_n = posx2;
    posy2_n = posy2;
    case (state_n)
      WHOLE: begin
        wx2     = x1_n + HALF_W;
        en1_n   = 1'b1;
        en2_n   = 1'b1;
        posx1_n = x1_n[9:0];
        posy1_n = y_n[9:0];
        posx2_n = wx2[9:0];
        posy2_n = y_n[9:0];
      end
      SPLIT: begin
        en1_n = alive1_n;
        en2_n = alive2_n;
        // Halves already dead before this cycle keep their last drawn position
        if (state == WHOLE || alive1) begin
          posx1_n = x1_n[9:0];
          posy1_n = y_n[9:0];
        end
        if (state == WHOLE || alive2) begin
          posx2_n = x2_n[9:0];
          posy2_n = y_n[9:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      x1      <= '0;
      x2      <= '0;
      y       <= '0;
      vx1     <= '0;
      vx2     <= '0;
      vy      <= '0;
      gcnt    <= '0;
      alive1  <= 1'b0;
      alive2  <= 1'b0;
      en1     <= 1'b0;
      en2     <= 1'b0;
      posx1   <= '0;
      posy1   <= '0;
      posx2   <= '0;
      posy2   <= '0;
      busy    <= 1'b0;
      cut_ack <= 1'b0;
      missed  <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      x1      <= x1_n;
      x2      <= x2_n;
      y       <= y_n;
      vx1     <= vx1_n;
      vx2     <= vx2_n;
      vy      <= vy_n;
      gcnt    <= gcnt_n;
      alive1  <= alive1_n;
      alive2  <= alive2_n;
      en1     <= en1_n;
      en2     <= en2_n;
      posx1   <= posx1_n;
      posy1   <= posy1_n;
      posx2   <= posx2_n;
      posy2   <= posy2_n;
      busy    <= busy_n;
      cut_ack <= cut_ack_n;
      missed  <= missed_n;
      done    <= done_n;
    end
  end

endmodule

// File: tb/tb_fruit_split_motion.sv
// Directed bench for fruit_split_motion: a per-cycle vector table plus hand-written
// sequences for miss, half retirement, cut/tick collision and mid-flight reset.
module tb_fruit_split_motion;

  logic       clk = 1'b0;
  logic       rst, frame_tick, launch, cut;
  logic [9:0] launch_x;
  logic [7:0] launch_vx, launch_vy;
  logic       en1, en2, busy, cut_ack, missed, done;
  logic [9:0] posx1, posy1, posx2, posy2;

  int checks = 0;
  int errors = 0;

  fruit_split_motion #(
    .SCREEN_W(640), .SCREEN_H(480), .OBJ_W(64),
    .LAUNCH_Y(479), .GRAVITY_DIV(4), .SPLIT_VX(2)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .launch(launch),
    .launch_x(launch_x), .launch_vx(launch_vx), .launch_vy(launch_vy), .cut(cut),
    .en1(en1), .en2(en2), .posx1(posx1), .posy1(posy1), .posx2(posx2), .posy2(posy2),
    .busy(busy), .cut_ack(cut_ack), .missed(missed), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r, t, l;
    logic [9:0] lx;
    logic [7:0] lvx, lvy;
    logic       c;
    logic       e1, e2;
    logic [9:0] px1, py, px2;
    logic       bz, ack, mis, dn;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(int r, int t, int l, int lx, int lvx, int lvy, int c,
                             int e1, int e2, int px1, int py, int px2,
                             int bz, int ack, int mis, int dn);
    vec_t o;
    o.r = 1'(r);   o.t = 1'(t);    o.l = 1'(l);     o.lx = 10'(lx);
    o.lvx = 8'(lvx); o.lvy = 8'(lvy); o.c = 1'(c);
    o.e1 = 1'(e1); o.e2 = 1'(e2);  o.px1 = 10'(px1); o.py = 10'(py); o.px2 = 10'(px2);
    o.bz = 1'(bz); o.ack = 1'(ack); o.mis = 1'(mis); o.dn = 1'(dn);
    return o;
  endfunction

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e1, input logic e2,
                         input logic [9:0] px1, input logic [9:0] py, input logic [9:0] px2,
                         input logic bz, input logic ack, input logic mis, input logic dn);
    chk({tag, ".en1"},     {11'd0, en1},     {11'd0, e1});
    chk({tag, ".en2"},     {11'd0, en2},     {11'd0, e2});
    chk({tag, ".posx1"},   {2'd0, posx1},    {2'd0, px1});
    chk({tag, ".posy1"},   {2'd0, posy1},    {2'd0, py});
    chk({tag, ".posx2"},   {2'd0, posx2},    {2'd0, px2});
    chk({tag, ".posy2"},   {2'd0, posy2},    {2'd0, py});
    chk({tag, ".busy"},    {11'd0, busy},    {11'd0, bz});
    chk({tag, ".cut_ack"}, {11'd0, cut_ack}, {11'd0, ack});
    chk({tag, ".missed"},  {11'd0, missed},  {11'd0, mis});
    chk({tag, ".done"},    {11'd0, done},    {11'd0, dn});
  endtask

  task automatic apply(input logic r, input logic t, input logic l, input logic [9:0] lx,
                       input logic [7:0] lvx, input logic [7:0] lvy, input logic c);
    rst = r; frame_tick = t; launch = l; launch_x = lx;
    launch_vx = lvx; launch_vy = lvy; cut = c;
    @(posedge clk);
    #1;
    rst = 1'b0; frame_tick = 1'b0; launch = 1'b0; cut = 1'b0;
  endtask

  task automatic tick();
    apply(1'b0, 1'b1, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic idle();
    apply(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic bit_chk(input string name, input logic act, input logic exp);
    chk(name, {11'd0, act}, {11'd0, exp});
  endtask

  initial begin
    rst = 1'b0; frame_tick = 1'b0; launch = 1'b0; cut = 1'b0;
    launch_x = '0; launch_vx = '0; launch_vy = '0;

    //        r t l  lx   vx  vy  c   e1 e2 px1 py  px2 bz ack mis dn
    vecs.push_back(v(1,0,0,   0,  0,  0, 0,  0, 0,   0,   0,   0, 0, 0, 0, 0));
    vecs.push_back(v(0,0,0,   0,  0,  0, 0,  0, 0,   0,   0,   0, 0, 0, 0, 0));
    vecs.push_back(v(0,0,1, 100,  2,-10, 0,  1, 1, 100, 479, 132, 1, 0, 0, 0));
    vecs.push_back(v(0,1,0,   0,  0,  0, 0,  1, 1, 102, 469, 134, 1, 0, 0, 0));
    vecs.push_back(v(0,1,0,   0,  0,  0, 0,  1, 1, 104, 459, 136, 1, 0, 0, 0));
    vecs.push_back(v(0,1,0,   0,  0,  0, 0,  1, 1, 106, 449, 138, 1, 0, 0, 0));
    vecs.push_back(v(0,1,0,   0,  0,  0, 0,  1, 1, 108, 439, 140, 1, 0, 0, 0));
    vecs.push_back(v(0,1,0,   0,  0,  0, 0,  1, 1, 110, 430, 142, 1, 0, 0, 0));
    vecs.push_back(v(0,0,0,   0,  0,  0, 0,  1, 1, 110, 430, 142, 1, 0, 0, 0));
    vecs.push_back(v(0,1,0,   0,  0,  0, 0,  1, 1, 112, 421, 144, 1, 0, 0, 0));
    vecs.push_back(v(0,1,0,   0,  0,  0, 0,  1, 1, 114, 412, 146, 1, 0, 0, 0));
    vecs.push_back(v(0,1,0,   0,  0,  0, 0,  1, 1, 116, 403, 148, 1, 0, 0, 0));
    vecs.push_back(v(0,1,0,   0,  0,  0, 0,  1, 1, 118, 395, 150, 1, 0, 0, 0));
    vecs.push_back(v(0,1,0,   0,  0,  0, 0,  1, 1, 120, 387, 152, 1, 0, 0, 0));
    vecs.push_back(v(0,0,0,   0,  0,  0, 1,  1, 1, 120, 387, 152, 1, 1, 0, 0));
    vecs.push_back(v(0,1,0,   0,  0,  0, 0,  1, 1, 120, 379, 156, 1, 0, 0, 0));
    vecs.push_back(v(0,0,0,   0,  0,  0, 1,  1, 1, 120, 379, 156, 1, 0, 0, 0));
    vecs.push_back(v(0,1,0,   0,  0,  0, 0,  1, 1, 120, 371, 160, 1, 0, 0, 0));
    vecs.push_back(v(1,0,0,   0,  0,  0, 0,  0, 0,   0,   0,   0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      apply(vecs[i].r, vecs[i].t, vecs[i].l, vecs[i].lx, vecs[i].lvx, vecs[i].lvy, vecs[i].c);
      chk_all($sformatf("vec%0d", i), vecs[i].e1, vecs[i].e2, vecs[i].px1, vecs[i].py,
              vecs[i].px2, vecs[i].bz, vecs[i].ack, vecs[i].mis, vecs[i].dn);
    end

    // Uncut fruit: vy=-2 from y=479 re-crosses the bottom on tick 21
    apply(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 10'd200, 8'd0, 8'hFE, 1'b0);
    for (int i = 1; i <= 21; i++) begin
      tick();
      bit_chk($sformatf("miss.t%0d.missed", i), missed, i == 21);
      bit_chk($sformatf("miss.t%0d.done", i), done, 1'b0);
      if (i == 20) chk("miss.t20.posy1", {2'd0, posy1}, 12'd479);
      if (i < 21) bit_chk($sformatf("miss.t%0d.busy", i), busy, 1'b1);
    end
    chk_all("miss.end", 1'b0, 1'b0, 10'd200, 10'd479, 10'd232, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    bit_chk("miss.after.missed", missed, 1'b0);

    // Left half exits at x<0, right half later exits through the bottom
    apply(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 10'd2, 8'd0, 8'd0, 1'b0);
    apply(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    chk_all("half.cut", 1'b1, 1'b1, 10'd2, 10'd479, 10'd34, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("half.t1", 1'b1, 1'b1, 10'd0, 10'd479, 10'd36, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    bit_chk("half.t2.en1", en1, 1'b0);
    bit_chk("half.t2.en2", en2, 1'b1);
    chk("half.t2.posx2", {2'd0, posx2}, 12'd38);
    bit_chk("half.t2.done", done, 1'b0);
    tick();
    chk("half.t3.posx2", {2'd0, posx2}, 12'd40);
    tick();
    chk("half.t4.posx2", {2'd0, posx2}, 12'd42);
    bit_chk("half.t4.en2", en2, 1'b1);
    bit_chk("half.t4.done", done, 1'b0);
    tick();
    bit_chk("half.t5.done", done, 1'b1);
    bit_chk("half.t5.en2", en2, 1'b0);
    bit_chk("half.t5.busy", busy, 1'b0);
    bit_chk("half.t5.missed", missed, 1'b0);
    idle();
    bit_chk("half.after.done", done, 1'b0);

    // Cut on the same tick that would have been a miss; then launch while split
    apply(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 10'd300, 8'd0, 8'd1, 1'b0);
    apply(1'b0, 1'b1, 1'b0, '0, '0, '0, 1'b1);
    chk_all("coll.cut", 1'b1, 1'b1, 10'd300, 10'd480, 10'd332, 1'b1, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 10'd10, 8'd5, 8'hF0, 1'b0);
    chk_all("coll.launch", 1'b1, 1'b1, 10'd300, 10'd480, 10'd332, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    bit_chk("coll.t1.done", done, 1'b1);
    bit_chk("coll.t1.missed", missed, 1'b0);
    bit_chk("coll.t1.en1", en1, 1'b0);
    bit_chk("coll.t1.en2", en2, 1'b0);
    bit_chk("coll.t1.busy", busy, 1'b0);
    idle();
    bit_chk("coll.after.done", done, 1'b0);

    // Reset during SPLIT aborts silently; next launch starts cleanly
    apply(1'b0, 1'b0, 1'b1, 10'd100, 8'd0, 8'hFB, 1'b0);
    apply(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    tick();
    apply(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    chk_all("rst.mid", 1'b0, 1'b0, 10'd0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 10'd50, 8'd1, 8'hFD, 1'b0);
    chk_all("rst.relaunch", 1'b1, 1'b1, 10'd50, 10'd479, 10'd82, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("rst.t1", 1'b1, 1'b1, 10'd51, 10'd476, 10'd83, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
